// File: rtl/vram_arbiter.sv
// Arbitrates the external video SRAM between display scanline fetches (strict priority)
// and CPU read/write requests. All SRAM pins are registered, so they are glitch-free.
// state     | meaning
// IDLE      | bus idle, OE/WE inactive
// DISP_RD   | display fetch, OE active
// CPU_RD    | CPU read, OE active
// CPU_WR    | CPU write, WE active, data driven
// RECOVER   | bus turnaround after a write
module vram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int VRAM_BASE  = 0,
  parameter int VRAM_WORDS = 307200
) (
  input  logic              clk_video,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_ovr,
  input  logic              cpu_rd_q,
  input  logic              cpu_wr_q,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_DISP_RD, S_CPU_RD, S_CPU_WR, S_RECOVER
  } state_t;

  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(VRAM_BASE);
  localparam logic [ADDR_W:0] WIN_SZ = (ADDR_W+1)'(VRAM_WORDS);

  state_t              state_q, state_d;
  logic                disp_pend_q, disp_pend_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic                disp_ovr_q, disp_ovr_d;
  logic                disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                cpu_blk_q, cpu_blk_d;
  logic                cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_drive_q, mem_drive_d;
  logic                mem_oe_n_q, mem_oe_n_d;
  logic                mem_we_n_q, mem_we_n_d;

  // A borrow out of the subtraction means the address is below the window.
  logic [ADDR_W+1:0]   cpu_off;
  logic                cpu_in_win;
  logic                cpu_pend;

  assign cpu_off    = {2'b00, cpu_addr} - {1'b0, WIN_LO};
  assign cpu_in_win = !cpu_off[ADDR_W+1] && (cpu_off[ADDR_W:0] < WIN_SZ);
  assign cpu_pend   = (cpu_rd_q || cpu_wr_q) && cpu_in_win && !cpu_blk_q;

  always_ff @(posedge clk_video) begin
    if (rst) begin
      state_q      <= S_IDLE;
      disp_pend_q  <= 1'b0;
      disp_addr_q  <= '0;
      disp_ovr_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_blk_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_drive_q  <= 1'b0;
      mem_oe_n_q   <= 1'b1;
      mem_we_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      disp_pend_q  <= disp_pend_d;
      disp_addr_q  <= disp_addr_d;
      disp_ovr_q   <= disp_ovr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      cpu_blk_q    <= cpu_blk_d;
      cpu_done_q   <= cpu_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_drive_q  <= mem_drive_d;
      mem_oe_n_q   <= mem_oe_n_d;
      mem_we_n_q   <= mem_we_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    disp_pend_d  = disp_pend_q;
    disp_addr_d  = disp_addr_q;
    disp_ovr_d   = disp_ovr_q;
    disp_valid_d = 1'b0;
    disp_data_d  = disp_data_q;
    cpu_blk_d    = cpu_blk_q;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_drive_d  = 1'b0;
    mem_oe_n_d   = 1'b1;
    mem_we_n_d   = 1'b1;

    unique case (state_q)
      S_CPU_WR: state_d = S_RECOVER;
      default: begin
        if (disp_req || disp_pend_q) state_d = S_DISP_RD;
        else if (cpu_pend)           state_d = cpu_wr_q ? S_CPU_WR : S_CPU_RD;
        else                         state_d = S_IDLE;
      end
    endcase

    // A pending fetch can only survive a CPU_WR cycle, so a second strobe
    // while one is still pending has lost the first address.
    if (disp_req) begin
      disp_addr_d = disp_addr;
      disp_pend_d = 1'b1;
      if (disp_pend_q) disp_ovr_d = 1'b1;
    end
    if (state_d == S_DISP_RD) disp_pend_d = 1'b0;

    unique case (state_d)
      S_DISP_RD: begin
        mem_oe_n_d = 1'b0;
        mem_addr_d = disp_req ? disp_addr : disp_addr_q;
      end
      S_CPU_RD: begin
        mem_oe_n_d = 1'b0;
        mem_addr_d = cpu_off[ADDR_W-1:0];
      end
      S_CPU_WR: begin
        mem_we_n_d  = 1'b0;
        mem_drive_d = 1'b1;
        mem_addr_d  = cpu_off[ADDR_W-1:0];
        mem_wdata_d = cpu_wdata;
      end
      default: ;
    endcase

    // Block re-acceptance of the serviced request until the CPU drops it.
    if (state_d == S_CPU_RD || state_d == S_CPU_WR) cpu_blk_d = 1'b1;
    else if (!cpu_rd_q && !cpu_wr_q)                 cpu_blk_d = 1'b0;

    if (state_q == S_DISP_RD) begin
      disp_valid_d = 1'b1;
      disp_data_d  = mem_rdata;
    end
    if (state_q == S_CPU_RD) begin
      cpu_done_d  = 1'b1;
      cpu_rdata_d = mem_rdata;
    end
    if (state_q == S_CPU_WR) cpu_done_d = 1'b1;
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign disp_ovr   = disp_ovr_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_done   = cpu_done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_drive  = mem_drive_q;
  assign mem_oe_n   = mem_oe_n_q;
  assign mem_we_n   = mem_we_n_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: SRAM model, reference memory, directed
// scenarios plus randomized display/CPU traffic.
module tb_vram_arbiter;
  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int BASE  = 0;
  localparam int WORDS = 307200;

  logic          clk_video = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid, disp_ovr;
  logic          cpu_rd_q = 1'b0, cpu_wr_q = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_drive, mem_oe_n, mem_we_n;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VRAM_BASE(BASE), .VRAM_WORDS(WORDS)) dut (
    .clk_video(clk_video), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_ovr(disp_ovr),
    .cpu_rd_q(cpu_rd_q), .cpu_wr_q(cpu_wr_q), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
    .mem_rdata(mem_rdata), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 clk_video = ~clk_video;

  typedef struct { logic [31:0] d; int c; } dexp_t;
  typedef struct { bit wr; logic [31:0] d; } cexp_t;
  dexp_t dq[$];
  cexp_t cq[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_valid = 0, n_done = 0, n_we = 0, n_oe = 0;
  logic [AW-1:0] we_addr = '0;
  logic [DW-1:0] we_data = '0;
  logic          we_drive = 1'b0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] sram    [0:1023];
  bit          sram_vld[0:1023];

  function automatic logic [31:0] init_val(input int a);
    if (a == 16) return 32'hA5A5A5A5;
    return (32'h9E3779B9 * 32'(a + 1)) ^ 32'(a);
  endfunction

  // SRAM model: written on WE low with the driver enabled, read while OE low
  always_comb begin
    mem_rdata = 32'h0;
    if (!mem_oe_n)
      mem_rdata = sram_vld[mem_addr[9:0]] ? sram[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
  end
  initial forever begin
    @(posedge clk_video);
    cyc++;
    if (!rst && !mem_we_n && mem_drive) begin
      sram[mem_addr[9:0]]     <= mem_wdata;
      sram_vld[mem_addr[9:0]] <= 1'b1;
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops scoreboard entries on each valid/done pulse
  initial forever begin
    dexp_t de;
    cexp_t ce;
    @(negedge clk_video);
    if (!rst) begin
      chk(mem_oe_n || mem_we_n, "oe_we_exclusive", {30'b0, mem_oe_n, mem_we_n}, 32'h1);
      chk(mem_drive == !mem_we_n, "drive_only_in_write", 32'(mem_drive), 32'(!mem_we_n));
      if (!mem_we_n) begin
        n_we++; we_addr = mem_addr; we_data = mem_wdata; we_drive = mem_drive;
      end
      if (!mem_oe_n) n_oe++;
      if (disp_valid) begin
        n_valid++;
        if (dq.size() == 0) chk(1'b0, "disp_valid_unexpected", disp_data, 32'h0);
        else begin
          de = dq.pop_front();
          chk(disp_data == de.d, "disp_data", disp_data, de.d);
          chk((cyc - de.c) inside {[2:3]}, "disp_latency", 32'(cyc - de.c), 32'd2);
        end
      end
      if (cpu_done) begin
        n_done++;
        if (cq.size() == 0) chk(1'b0, "cpu_done_unexpected", cpu_rdata, 32'h0);
        else begin
          ce = cq.pop_front();
          if (!ce.wr) chk(cpu_rdata == ce.d, "cpu_rdata", cpu_rdata, ce.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_video);
    #1;
  endtask

  task automatic disp_issue(input logic [AW-1:0] a);
    disp_req  = 1'b1;
    disp_addr = a;
    dq.push_back('{ref_mem[a[9:0]], cyc});
  endtask

  task automatic cpu_op(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit both, input int hold);
    bit got = 1'b0;
    if (wr) begin
      ref_mem[a[9:0]] = d;
      cq.push_back('{1'b1, 32'h0});
    end else cq.push_back('{1'b0, ref_mem[a[9:0]]});
    cpu_addr = a; cpu_wdata = d; cpu_wr_q = wr; cpu_rd_q = !wr || both;
    for (int k = 0; k < 60 && !got; k++) begin
      tick;
      if (cpu_done) got = 1'b1;
    end
    chk(got, "cpu_done_timeout", 32'(got), 32'h1);
    repeat (hold) tick;
    cpu_rd_q = 1'b0; cpu_wr_q = 1'b0;
    tick;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(mem_oe_n == 1'b1, {tag, "_oe_n"}, 32'(mem_oe_n), 32'h1);
    chk(mem_we_n == 1'b1, {tag, "_we_n"}, 32'(mem_we_n), 32'h1);
    chk(mem_drive == 1'b0, {tag, "_drive"}, 32'(mem_drive), 32'h0);
    chk(mem_addr == '0, {tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk(mem_wdata == '0, {tag, "_wdata"}, mem_wdata, 32'h0);
    chk(disp_valid == 1'b0, {tag, "_disp_valid"}, 32'(disp_valid), 32'h0);
    chk(cpu_done == 1'b0, {tag, "_cpu_done"}, 32'(cpu_done), 32'h0);
    chk(disp_ovr == 1'b0, {tag, "_disp_ovr"}, 32'(disp_ovr), 32'h0);
    chk(disp_data == '0, {tag, "_disp_data"}, disp_data, 32'h0);
    chk(cpu_rdata == '0, {tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    int v0, d0, w0, o0;
    bit got;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    // reset held 3 cycles
    rst = 1'b1;
    repeat (3) tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick;

    // single display fetch: latency 2
    disp_issue(20'h00010);
    tick;
    disp_req = 1'b0;
    chk(mem_oe_n == 1'b0, "t2_oe_n", 32'(mem_oe_n), 32'h0);
    chk(mem_addr == 20'h00010, "t2_addr", 32'(mem_addr), 32'h10);
    tick;
    chk(disp_valid == 1'b1, "t2_valid", 32'(disp_valid), 32'h1);
    chk(disp_data == 32'hA5A5A5A5, "t2_data", disp_data, 32'hA5A5A5A5);
    repeat (2) tick;

    // display and CPU read in the same cycle: display first
    v0 = n_valid; d0 = n_done;
    disp_issue(20'h00020);
    cpu_rd_q = 1'b1; cpu_addr = 20'(BASE + 3);
    cq.push_back('{1'b0, ref_mem[3]});
    tick;
    disp_req = 1'b0;
    chk(mem_oe_n == 1'b0 && mem_addr == 20'h00020, "t3_disp_first", 32'(mem_addr), 32'h20);
    tick;
    chk(mem_oe_n == 1'b0 && mem_addr == 20'd3, "t3_cpu_second", 32'(mem_addr), 32'h3);
    tick;
    chk(cpu_done == 1'b1, "t3_done", 32'(cpu_done), 32'h1);
    cpu_rd_q = 1'b0;
    repeat (3) tick;
    chk(n_valid - v0 == 1, "t3_valid_count", 32'(n_valid - v0), 32'h1);
    chk(n_done - d0 == 1, "t3_done_count", 32'(n_done - d0), 32'h1);

    // CPU write squeezed between fetches every 2 cycles
    d0 = n_done; w0 = n_we;
    fork
      for (int i = 0; i < 8; i++) begin
        disp_issue(20'(32'h30 + i));
        tick;
        disp_req = 1'b0;
        tick;
      end
      cpu_op(1'b1, 20'(BASE + 5), 32'h12345678, 1'b0, 0);
    join
    repeat (3) tick;
    chk(n_we - w0 == 1, "t4_we_cycles", 32'(n_we - w0), 32'h1);
    chk(we_addr == 20'd5, "t4_we_addr", 32'(we_addr), 32'h5);
    chk(we_data == 32'h12345678, "t4_we_data", we_data, 32'h12345678);
    chk(we_drive == 1'b1, "t4_we_drive", 32'(we_drive), 32'h1);
    chk(n_done - d0 == 1, "t4_done_count", 32'(n_done - d0), 32'h1);
    chk(disp_ovr == 1'b0, "t4_no_ovr", 32'(disp_ovr), 32'h0);

    // out-of-window read just past the top: never serviced
    d0 = n_done; w0 = n_we; o0 = n_oe;
    cpu_rd_q = 1'b1; cpu_addr = 20'(BASE + WORDS);
    repeat (100) tick;
    cpu_rd_q = 1'b0;
    tick;
    chk(n_oe == o0, "t5_no_oe", 32'(n_oe - o0), 32'h0);
    chk(n_we == w0, "t5_no_we", 32'(n_we - w0), 32'h0);
    chk(n_done == d0, "t5_no_done", 32'(n_done - d0), 32'h0);

    // randomized traffic: display region 0..511, CPU writes 512..1023
    fork
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          disp_issue(20'($urandom_range(0, 511)));
          tick;
          disp_req = 1'b0;
          tick;
        end else tick;
      end
      for (int k = 0; k < 40; k++) begin
        bit wr;
        logic [AW-1:0] a;
        wr = 1'($urandom);
        a  = wr ? 20'($urandom_range(512, 1023)) : 20'($urandom_range(0, 1023));
        cpu_op(wr, a, $urandom, wr && 1'($urandom), int'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 3)) tick;
      end
    join
    repeat (5) tick;
    chk(disp_ovr == 1'b0, "rand_no_ovr", 32'(disp_ovr), 32'h0);
    chk(dq.size() == 0, "rand_disp_drained", 32'(dq.size()), 32'h0);
    chk(cq.size() == 0, "rand_cpu_drained", 32'(cq.size()), 32'h0);

    // two fetch strobes back to back around a write: overrun, second wins
    cpu_wr_q = 1'b1; cpu_addr = 20'h00200; cpu_wdata = 32'hCAFEF00D;
    ref_mem[10'h200] = 32'hCAFEF00D;
    cq.push_back('{1'b1, 32'h0});
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick;
      if (!mem_we_n) got = 1'b1;
    end
    chk(got, "t6_write_seen", 32'(got), 32'h1);
    disp_req = 1'b1; disp_addr = 20'h00040;
    tick;
    disp_issue(20'h00041);
    chk(cpu_done == 1'b1, "t6_done_in_recover", 32'(cpu_done), 32'h1);
    cpu_wr_q = 1'b0;
    tick;
    disp_req = 1'b0;
    chk(disp_ovr == 1'b1, "t6_ovr_set", 32'(disp_ovr), 32'h1);
    chk(mem_oe_n == 1'b0 && mem_addr == 20'h00041, "t6_second_fetched", 32'(mem_addr), 32'h41);
    repeat (6) tick;
    chk(disp_ovr == 1'b1, "t6_ovr_sticky", 32'(disp_ovr), 32'h1);
    chk(dq.size() == 0, "t6_disp_drained", 32'(dq.size()), 32'h0);
    rst = 1'b1;
    repeat (2) tick;
    check_reset_outputs("final_reset");
    rst = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1);
  end
endmodule
